// File: rtl/battousai_store_rmw.sv
// battousai_store_rmw: RISC-V sb/sh/sw/sd executor, partial stores as read-modify-write of a 64-bit doubleword
module battousai_store_rmw #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] sz_q;
  logic [63:0] addr_q, sd_q;
  logic err_q;
  logic legal;
  logic unused_instr;
  assign legal = instr[6:0] == 7'h23 && !instr[14];
  assign unused_instr = ^{instr[31:15], instr[11:7]};
  function automatic logic [63:0] merge(input logic [63:0] rd, input logic [63:0] sd, input logic [1:0] sz);
    return sz == 2'd0 ? {rd[63:8], sd[7:0]} :
           sz == 2'd1 ? {rd[63:16], sd[15:0]} :
           sz == 2'd2 ? {rd[63:32], sd[31:0]} : sd;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = !legal ? DONE : instr[13:12] == 2'd3 ? WRITE : READ;
      READ:  nxt = WAIT;
      WAIT:  if (cnt == CW'(1)) nxt = WRITE;
      WRITE: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // mem_addr/mem_wdata load on entry to the access state so they are valid for its whole cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      sz_q <= '0;
      addr_q <= '0;
      sd_q <= '0;
      err_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        sz_q <= instr[13:12];
        addr_q <= addr;
        sd_q <= store_data;
        err_q <= !legal;
      end
      if (state == READ) cnt <= CW'(MEM_LAT);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (nxt == READ || nxt == WRITE) mem_addr <= state == IDLE ? addr : addr_q;
      if (nxt == WRITE) mem_wdata <= state == IDLE ? store_data : merge(mem_rdata, sd_q, sz_q);
    end
  assign mem_wr = state == WRITE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err = done && err_q;
endmodule

// File: tb/tb_battousai_store_rmw.sv
// tb_battousai_store_rmw: two DUTs (MEM_LAT 1 and 3) against a per-operation behavioural model
module tb_battousai_store_rmw;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic start[2];
  logic [31:0] instr[2];
  logic [63:0] addr[2], sdat[2], rdata[2], maddr[2], wdata[2];
  logic wr[2], busy[2], done[2], err[2];
  battousai_store_rmw #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start[0]), .instr(instr[0]), .addr(addr[0]),
    .store_data(sdat[0]), .mem_rdata(rdata[0]), .mem_addr(maddr[0]), .mem_wr(wr[0]),
    .mem_wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
  battousai_store_rmw #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start[1]), .instr(instr[1]), .addr(addr[1]),
    .store_data(sdat[1]), .mem_rdata(rdata[1]), .mem_addr(maddr[1]), .mem_wr(wr[1]),
    .mem_wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic legal(input logic [31:0] i);
    return i[6:0] == 7'h23 && i[14:12] < 3'd4;
  endfunction
  function automatic int lat_of(input int g, input logic [31:0] i);
    return !legal(i) ? 1 : i[14:12] == 3'd3 ? 2 : 3 + (g == 0 ? 1 : 3);
  endfunction
  function automatic logic [63:0] upd(input logic [63:0] o, input logic [63:0] s, input logic [31:0] i);
    logic [63:0] m;
    m = i[14:12] == 3'd3 ? '1 : (64'd1 << (8 << i[14:12])) - 64'd1;
    return legal(i) ? (o & ~m) | (s & m) : o;
  endfunction
  logic ld = 1'b0;
  int ld_i = 0;
  int ld_x = 0;
  logic [63:0] ld_v = '0;
  logic [63:0] mem[2][16];
  logic [63:0] refm[2][16];
  logic [63:0] pipe[2][3];
  int nwr[2] = '{0, 0};
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];
  always @(posedge clk) begin
    if (ld) mem[ld_i][ld_x] <= ld_v;
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= mem[g][maddr[g][6:3]];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
      if (wr[g]) begin
        mem[g][maddr[g][6:3]] <= wdata[g];
        nwr[g] <= nwr[g] + 1;
      end
    end
  end
  // Model: each accepted op occupies lat cycles; write in the second-to-last, done in the last
  int rem[2] = '{0, 0};
  logic leg_q[2] = '{1'b0, 1'b0};
  logic [3:0] ridx[2];
  logic [63:0] old[2], exp_w[2], exp_a[2];
  always @(posedge clk or negedge reset) begin
    if (ld) refm[ld_i][ld_x] <= ld_v;
    for (int g = 0; g < 2; g++)
      if (!reset) begin
        if (rem[g] > 2) refm[g][ridx[g]] <= old[g];
        rem[g] <= 0;
      end else if (rem[g] > 0) rem[g] <= rem[g] - 1;
      else if (start[g]) begin
        rem[g] <= lat_of(g, instr[g]);
        leg_q[g] <= legal(instr[g]);
        ridx[g] <= addr[g][6:3];
        old[g] <= refm[g][addr[g][6:3]];
        exp_a[g] <= addr[g];
        exp_w[g] <= upd(refm[g][addr[g][6:3]], sdat[g], instr[g]);
        refm[g][addr[g][6:3]] <= upd(refm[g][addr[g][6:3]], sdat[g], instr[g]);
      end
  end
  always @(negedge clk)
    if (reset && !ld)
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ctl%0d", g), {60'd0, busy[g], done[g], err[g], wr[g]},
            {60'd0, rem[g] > 0, rem[g] == 1, rem[g] == 1 && !leg_q[g], leg_q[g] && rem[g] == 2});
        if (leg_q[g] && rem[g] == 2) begin
          chk($sformatf("waddr%0d", g), maddr[g], exp_a[g]);
          chk($sformatf("wdata%0d", g), wdata[g], exp_w[g]);
        end
      end
  task automatic chk_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, "_addr"}, maddr[g], 64'd0);
      chk({nm, "_wdata"}, wdata[g], 64'd0);
      chk({nm, "_ctl"}, {60'd0, wr[g], busy[g], done[g], err[g]}, 64'd0);
    end
  endtask
  task automatic op(input int i, input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] a,
                    input logic [63:0] sd, input bit poke, output int dl);
    logic [31:0] ins;
    int w0;
    ins = $urandom;
    ins[14:12] = f3;
    ins[6:0] = opc;
    @(negedge clk);
    instr[i] = ins;
    addr[i] = a;
    sdat[i] = sd;
    start[i] = 1'b1;
    w0 = nwr[i];
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    instr[i] = $urandom;
    addr[i] = {$urandom, $urandom};
    sdat[i] = {$urandom, $urandom};
    dl = 0;
    do begin
      @(negedge clk);
      dl++;
      if (dl == 1) start[i] = poke;
      if (dl == 2) start[i] = 1'b0;
    end while (!done[i] && dl < 40);
    start[i] = 1'b0;
    chk("latency", dl, lat_of(i, ins));
    chk("err", {63'd0, err[i]}, {63'd0, !legal(ins)});
    chk("writes", nwr[i] - w0, legal(ins) ? 1 : 0);
  endtask
  int dl, k, w0;
  logic [63:0] prev;
  initial begin
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      instr[g] = '0;
      addr[g] = '0;
      sdat[g] = '0;
    end
    for (int g = 0; g < 2; g++)
      for (int x = 0; x < 16; x++) begin
        @(negedge clk);
        ld = 1'b1;
        ld_i = g;
        ld_x = x;
        ld_v = (g == 0 && x == 8) ? 64'h1122334455667788 : {$urandom, $urandom};
      end
    @(negedge clk);
    ld = 1'b0;
    chk_zero("reset");
    @(posedge clk);
    #2 reset = 1'b1;
    op(0, 7'h23, 3'd0, 64'h40, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, dl);
    chk("sb_done", dl, 4);
    chk("sb_mem", mem[0][8], 64'h11223344556677AB);
    chk("sb_model", refm[0][8], 64'h11223344556677AB);
    op(0, 7'h23, 3'd1, 64'h40, 64'h1234_5678_9ABC_BEEF, 1'b0, dl);
    chk("sh_done", dl, 4);
    chk("sh_mem", mem[0][8], 64'h112233445566BEEF);
    op(0, 7'h23, 3'd2, 64'h40, 64'h5555_5555_CAFE_BABE, 1'b0, dl);
    chk("sw_done", dl, 4);
    chk("sw_mem", mem[0][8], 64'h11223344CAFEBABE);
    op(0, 7'h23, 3'd3, 64'h40, 64'h0123456789ABCDEF, 1'b0, dl);
    chk("sd_done", dl, 2);
    chk("sd_mem", mem[0][8], 64'h0123456789ABCDEF);
    op(0, 7'h23, 3'd5, 64'h40, 64'hDEAD, 1'b0, dl);
    chk("ill_f3_done", dl, 1);
    op(0, 7'h03, 3'd0, 64'h40, 64'hDEAD, 1'b0, dl);
    chk("ill_op_done", dl, 1);
    chk("ill_mem", mem[0][8], 64'h0123456789ABCDEF);
    prev = mem[0][3];
    w0 = nwr[0];
    @(negedge clk);
    instr[0] = 32'h0000_0023;
    addr[0] = 64'h18;
    sdat[0] = 64'h77;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("abort");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy[0]}, 64'd0);
    chk("abort_mem", mem[0][3], prev);
    chk("abort_model", refm[0][3], prev);
    chk("abort_writes", nwr[0] - w0, 0);
    op(1, 7'h23, 3'd0, 64'h48, 64'h99, 1'b1, dl);
    chk("lat3_sb_done", dl, 6);
    w0 = nwr[1];
    @(negedge clk);
    instr[1] = 32'h0000_2023;
    addr[1] = 64'h10;
    sdat[1] = 64'hAAAA_BBBB_1357_9BDF;
    start[1] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done[1] && k < 40);
    chk("held_first_done", k, 6);
    instr[1] = 32'h0000_3023;
    addr[1] = 64'h20;
    sdat[1] = 64'hFEDC_BA98_7654_3210;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) start[1] = 1'b0;
    end while (!done[1] && k < 40);
    start[1] = 1'b0;
    chk("held_second_done", k, 3);
    chk("held_writes", nwr[1] - w0, 2);
    chk("held_sd_mem", mem[1][4], 64'hFEDC_BA98_7654_3210);
    chk("held_sw_mem", mem[1][2] & 64'hFFFF_FFFF, 64'h1357_9BDF);
    repeat (80) begin
      op($urandom_range(0, 1), $urandom_range(0, 9) == 0 ? 7'h03 : 7'h23,
         $urandom_range(0, 4) == 4 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
         {57'd0, 4'($urandom_range(0, 15)), 3'd0}, {$urandom, $urandom}, bit'($urandom_range(0, 1)), dl);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++)
      for (int x = 0; x < 16; x++) chk($sformatf("final_mem%0d_%0d", g, x), mem[g][x], refm[g][x]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
